// File: rtl/hls_ctrl_pkg.sv
// Shared types and default constants for the HLS ap_ctrl_hs sequencer.
package hls_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ERROR     = 2'd3
  } state_e;

  localparam int DEF_PERIOD  = 10000;
  localparam int DEF_TIMEOUT = 100000;
  localparam int DEF_CNT_W   = 32;

endpackage

// File: rtl/hls_ap_sequencer_tick.sv
// Periodic trigger source: tick pulses once every PERIOD cycles while enable is high.
module ap_tick_gen
  import hls_ctrl_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Held at zero while disabled so the first tick lands PERIOD cycles after enable rises.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hls_ap_sequencer.sv
// Runs one HLS accelerator over ap_ctrl_hs: triggers, launches, times each run with a watchdog,
// and keeps run/overrun statistics. dbg_state exposes the FSM state.
module hls_ap_sequencer
  import hls_ctrl_pkg::*;
#(
  parameter int PERIOD  = DEF_PERIOD,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             enable,
  input  logic             sw_start,
  input  logic             clear_err,
  input  logic             ap_done,
  input  logic             ap_ready,
  input  logic             ap_idle,
  output logic             ap_start,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state;
  logic [CNT_W-1:0] lat_cnt;
  logic             trig_pending;
  logic             tick;
  logic             trig;
  logic             active;
  logic             launch;
  logic             timeout_now;

  ap_tick_gen #(
    .PERIOD (PERIOD),
    .CNT_W  (CNT_W)
  ) u_tick (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .enable (enable),
    .tick   (tick)
  );

  assign trig        = tick | sw_start;
  assign active      = (state == ST_START) || (state == ST_WAIT_DONE);
  assign launch      = (state == ST_IDLE) && trig_pending && ap_idle;
  // A done in the last allowed cycle beats the watchdog.
  assign timeout_now = active && !ap_done && (lat_cnt == TMO_LAST);

  assign busy      = active;
  assign err       = (state == ST_ERROR);
  assign dbg_state = state;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state        <= ST_IDLE;
      ap_start     <= 1'b0;
      lat_cnt      <= '0;
      last_latency <= '0;
      run_cnt      <= '0;
      overrun_cnt  <= '0;
      trig_pending <= 1'b0;
    end else begin
      // Triggers are dropped silently in ERROR and on the cycle that enters it.
      if (state == ST_ERROR || timeout_now) begin
        trig_pending <= 1'b0;
      end else if (trig) begin
        trig_pending <= 1'b1;
        if (trig_pending && !launch && overrun_cnt != '1) begin
          overrun_cnt <= overrun_cnt + 1'b1;
        end
      end else if (launch) begin
        trig_pending <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (launch) begin
            state    <= ST_START;
            ap_start <= 1'b1;
            lat_cnt  <= '0;
          end
        end
        ST_START, ST_WAIT_DONE: begin
          if (ap_done) begin
            state        <= ST_IDLE;
            ap_start     <= 1'b0;
            last_latency <= lat_cnt + 1'b1;
            run_cnt      <= run_cnt + 1'b1;
          end else if (timeout_now) begin
            state    <= ST_ERROR;
            ap_start <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
            if (state == ST_START && ap_ready) begin
              state    <= ST_WAIT_DONE;
              ap_start <= 1'b0;
            end
          end
        end
        ST_ERROR: begin
          if (clear_err) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          ap_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hls_ap_sequencer.sv
// Bench for hls_ap_sequencer: run-level reference model checked every cycle plus directed scenarios.
module tb_hls_ap_sequencer;
  import hls_ctrl_pkg::*;

  localparam int PERIOD  = 10;
  localparam int TIMEOUT = 20;
  localparam int CNT_W   = 32;

  logic             HCLK;
  logic             HRESET;
  logic             enable;
  logic             sw_start;
  logic             clear_err;
  logic             ap_done;
  logic             ap_ready;
  logic             ap_idle;
  logic             ap_start;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] last_latency;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] overrun_cnt;
  logic [1:0]       dbg_state;

  int tests = 0;
  int fails = 0;

  hls_ap_sequencer #(
    .PERIOD  (PERIOD),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .enable       (enable),
    .sw_start     (sw_start),
    .clear_err    (clear_err),
    .ap_done      (ap_done),
    .ap_ready     (ap_ready),
    .ap_idle      (ap_idle),
    .ap_start     (ap_start),
    .busy         (busy),
    .err          (err),
    .last_latency (last_latency),
    .run_cnt      (run_cnt),
    .overrun_cnt  (overrun_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- accelerator responder ----------------
  int   rdy_d = 2;
  int   done_d = 5;
  int   acc_age = 0;
  logic in_run = 1'b0;
  logic idle_hold = 1'b0;

  assign ap_idle = !in_run && !idle_hold;

  always @(negedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      in_run   = 1'b0;
      acc_age  = 0;
      ap_ready = 1'b0;
      ap_done  = 1'b0;
    end else begin
      if (err) in_run = 1'b0;
      else if (in_run && ap_done) in_run = 1'b0;
      else if (in_run) acc_age++;
      else if (ap_start) begin
        in_run  = 1'b1;
        acc_age = 0;
      end
      ap_ready = in_run && (acc_age == rdy_d);
      ap_done  = in_run && (done_d >= 0) && (acc_age == done_d);
    end
  end

  // ---------------- reference model (run-level view) ----------------
  logic        m_run, m_err, m_pending, m_ready_seen, m_tick, m_trig, m_launch;
  int          m_age, en_age;
  logic [31:0] m_last, m_runs, m_ovr;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      m_run = 0; m_err = 0; m_pending = 0; m_ready_seen = 0;
      m_age = 0; en_age = 0; m_last = 0; m_runs = 0; m_ovr = 0;
    end else begin
      m_tick   = enable && (((en_age + 1) % PERIOD) == 0);
      en_age   = enable ? en_age + 1 : 0;
      m_trig   = m_tick || sw_start;
      m_launch = !m_run && !m_err && m_pending && ap_idle;
      if (m_err) begin
        if (clear_err) m_err = 0;
      end else if (m_run && !ap_done && m_age == TIMEOUT - 1) begin
        m_run = 0; m_err = 1; m_pending = 0;
      end else begin
        if (m_trig) begin
          if (m_pending && !m_launch && m_ovr != 32'hFFFF_FFFF) m_ovr++;
          m_pending = 1;
        end else if (m_launch) m_pending = 0;
        if (m_launch) begin
          m_run = 1; m_age = 0; m_ready_seen = 0;
        end else if (m_run) begin
          if (ap_done) begin
            m_last = m_age + 1; m_runs++; m_run = 0;
          end else begin
            m_age++;
            if (ap_ready) m_ready_seen = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare + monitors ----------------
  int   cyc = 0, done_edge = 0, rise_edge = 0, err_edge = 0, rises = 0, hi_cnt = 0;
  logic saw_wait = 0, prev_start = 0, prev_err = 0;
  logic [1:0] exp_state;

  always @(posedge HCLK) begin
    cyc++;
    if (ap_done) done_edge = cyc;
    #1;
    if (!HRESET) begin
      exp_state = m_err ? ST_ERROR : (!m_run ? ST_IDLE : (m_ready_seen ? ST_WAIT_DONE : ST_START));
      check("cyc_ap_start", ap_start, m_run && !m_ready_seen);
      check("cyc_busy", busy, m_run);
      check("cyc_err", err, m_err);
      check("cyc_state", dbg_state, exp_state);
      check("cyc_last_latency", last_latency, m_last);
      check("cyc_run_cnt", run_cnt, m_runs);
      check("cyc_overrun_cnt", overrun_cnt, m_ovr);
    end
    if (ap_start && !prev_start) begin rise_edge = cyc; rises++; end
    if (err && !prev_err) err_edge = cyc;
    if (ap_start) hi_cnt++;
    if (dbg_state == ST_WAIT_DONE) saw_wait = 1;
    prev_start = ap_start;
    prev_err   = err;
  end

  // ---------------- driver tasks ----------------
  task automatic launch_sw();
    int lat;
    sw_start = 1'b1;
    lat = 0;
    @(posedge HCLK); #1; lat = 1;
    @(negedge HCLK); sw_start = 1'b0;
    while (!ap_start && lat < 50) begin
      @(posedge HCLK); #1; lat++;
    end
    check("sw_to_ap_start_latency", lat, 2);
    @(negedge HCLK);
  endtask

  task automatic pulse_sw();
    sw_start = 1'b1;
    @(negedge HCLK); sw_start = 1'b0;
  endtask

  task automatic wait_runs(input int target);
    int n = 0;
    while (run_cnt != target && n < 80) begin
      @(posedge HCLK); #1; n++;
    end
    check("wait_run_cnt", run_cnt, target);
    @(negedge HCLK);
  endtask

  // ---------------- directed scenarios ----------------
  int n, r1, d, r_before;

  initial begin
    HRESET = 1'b1; enable = 0; sw_start = 0; clear_err = 0;
    repeat (2) @(negedge HCLK);
    check("rst_ap_start", ap_start, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_run_cnt", run_cnt, 0);
    HRESET = 1'b0;
    @(negedge HCLK);

    // Asynchronous reset in the middle of a run
    rdy_d = 2; done_d = 5;
    launch_sw();
    @(posedge HCLK); #3;
    HRESET = 1'b1;
    #1;
    check("async_rst_ap_start", ap_start, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_state", dbg_state, ST_IDLE);
    check("async_rst_last_latency", last_latency, 0);
    @(negedge HCLK); HRESET = 1'b0;
    repeat (2) @(negedge HCLK);

    // Periodic runs
    enable = 1'b1;
    n = 0;
    while (!ap_start && n < 40) begin @(posedge HCLK); #1; n++; end
    check("first_periodic_start", n, 11);
    r1 = rise_edge;
    @(negedge HCLK);
    wait_runs(1);
    check("periodic_latency", last_latency, 6);
    n = 0;
    while (rises < 3 && n < 40) begin @(posedge HCLK); #1; n++; end
    check("period_spacing", rise_edge - r1, 10);
    @(negedge HCLK); enable = 1'b0;
    wait_runs(2);
    repeat (15) @(negedge HCLK);
    check("no_run_after_disable", run_cnt, 2);

    // Combined ready/done on the third ap_start cycle
    rdy_d = 2; done_d = 2; hi_cnt = 0; saw_wait = 0;
    launch_sw();
    wait_runs(3);
    check("combo_ap_start_cycles", hi_cnt, 3);
    check("combo_no_wait_done", saw_wait, 0);
    check("combo_latency", last_latency, 3);

    // Overrun: three extra triggers during a 15-cycle run
    rdy_d = 2; done_d = 14;
    launch_sw();
    repeat (2) @(negedge HCLK); pulse_sw();
    repeat (2) @(negedge HCLK); pulse_sw();
    repeat (2) @(negedge HCLK); pulse_sw();
    wait_runs(4);
    check("overrun_cnt", overrun_cnt, 2);
    check("overrun_latency", last_latency, 15);
    d = done_edge; r_before = rises;
    wait_runs(5);
    check("followup_start_edge", rise_edge, d + 1);
    check("followup_single", rises, r_before + 1);
    repeat (20) @(negedge HCLK);
    check("no_third_run", run_cnt, 5);

    // Timeout, ignored trigger in ERROR, clear
    rdy_d = 2; done_d = -1;
    launch_sw();
    n = 0;
    while (!err && n < 60) begin @(posedge HCLK); #1; n++; end
    check("timeout_err", err, 1);
    check("timeout_cycles", err_edge - rise_edge, 20);
    check("timeout_ap_start", ap_start, 0);
    check("timeout_run_cnt", run_cnt, 5);
    @(negedge HCLK);
    pulse_sw();
    repeat (3) @(negedge HCLK);
    check("err_trigger_no_overrun", overrun_cnt, 2);
    check("err_held", err, 1);
    clear_err = 1'b1;
    @(negedge HCLK); clear_err = 1'b0;
    check("clear_to_idle", dbg_state, ST_IDLE);
    check("clear_err_low", err, 0);
    done_d = 3;
    launch_sw();
    wait_runs(6);
    check("post_clear_latency", last_latency, 4);

    // Done arriving on the last allowed cycle
    rdy_d = 2; done_d = 19;
    launch_sw();
    wait_runs(7);
    check("tie_err", err, 0);
    check("tie_latency", last_latency, 20);

    // ap_idle gating
    rdy_d = 1; done_d = 3; idle_hold = 1'b1;
    pulse_sw();
    repeat (5) @(negedge HCLK);
    check("gated_no_start", ap_start, 0);
    check("gated_not_busy", busy, 0);
    idle_hold = 1'b0;
    @(posedge HCLK); #1;
    check("ungated_start", ap_start, 1);
    @(negedge HCLK);
    wait_runs(8);
    check("gated_latency", last_latency, 4);
    check("final_overrun", overrun_cnt, 2);

    repeat (3) @(negedge HCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
